// File: rtl/spmv_pkg.sv
// Shared types and address helpers for the SpMV dense-vector gather path.
package spmv_pkg;

    localparam int LINE_BYTES     = 64;
    localparam int WORDS_PER_LINE = 16;
    localparam int PADDR_W        = 40;
    localparam int LINE_W         = 34;

    // Gather sequencing: accept a beat, collect its x words, present the beat.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GATHER = 2'd1,
        ST_OUT    = 2'd2
    } gather_state_t;

    // One in-flight line request: which 64 B line it fetches, and whether it is live.
    typedef struct packed {
        logic              valid;
        logic [LINE_W-1:0] line;
    } slot_t;

    // Byte address of x[idx]; the sum wraps at the physical address width.
    function automatic logic [PADDR_W-1:0] addr_of(input logic [PADDR_W-1:0] x_base,
                                                   input logic [31:0]        idx);
        return x_base + {6'b0, idx, 2'b00};
    endfunction

    // Cache line holding x[idx].
    function automatic logic [LINE_W-1:0] line_of(input logic [PADDR_W-1:0] x_base,
                                                  input logic [31:0]        idx);
        logic [PADDR_W-1:0] a;
        a = addr_of(x_base, idx);
        return a[PADDR_W-1:6];
    endfunction

    // 32-bit word position of x[idx] inside its line.
    function automatic logic [3:0] word_of(input logic [PADDR_W-1:0] x_base,
                                           input logic [31:0]        idx);
        logic [PADDR_W-1:0] a;
        a = addr_of(x_base, idx);
        return a[5:2];
    endfunction

endpackage

// File: rtl/spmv_prio_enc.sv
// Lowest-set-bit priority encoder: reports whether any request bit is set
// and the index of the lowest one.
module spmv_prio_enc #(
    parameter int N     = 16,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                found = 1'b1;
                idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/spmv_x_gather.sv
// Dense-vector gather for SpMV: fetches x[col_idx] for one beat of lanes,
// merging lanes that share a 64 B line into a single memory request, and
// returns a lane-aligned beat of x values.
module spmv_x_gather
    import spmv_pkg::*;
#(
    parameter int         CHAN_NUM  = 16,
    parameter int         SPM_ELE_W = 32,
    parameter int         MAX_OUT   = 4,
    parameter logic [5:0] TID_BASE  = 6'd8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            spmv_init,
    input  logic [PADDR_W-1:0]              x_base,
    input  logic                            in_val,
    output logic                            in_rdy,
    input  logic [SPM_ELE_W*CHAN_NUM-1:0]   in_col_idx,
    input  logic [CHAN_NUM-1:0]             in_lane_mask,
    input  logic                            mem_req_rdy,
    output logic                            mem_req_val,
    output logic [5:0]                      mem_req_transid,
    output logic [PADDR_W-1:0]              mem_req_addr,
    input  logic                            mem_resp_val,
    input  logic [5:0]                      mem_resp_transid,
    input  logic [511:0]                    mem_resp_data,
    output logic                            out_val,
    input  logic                            out_rdy,
    output logic [SPM_ELE_W*CHAN_NUM-1:0]   out_x
);

    localparam int LANE_W = (CHAN_NUM > 1) ? $clog2(CHAN_NUM) : 1;
    localparam int SLOT_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

    gather_state_t          state;
    gather_state_t          state_nxt;
    logic                   clr;

    logic [SPM_ELE_W-1:0]   col_q    [CHAN_NUM];
    logic [PADDR_W-1:0]     base_q;
    logic [CHAN_NUM-1:0]    filled;
    logic [SPM_ELE_W-1:0]   x_q      [CHAN_NUM];
    slot_t                  slots    [MAX_OUT];

    logic [LINE_W-1:0]      lane_line [CHAN_NUM];
    logic [3:0]             lane_word [CHAN_NUM];
    logic [CHAN_NUM-1:0]    pending;
    logic [CHAN_NUM-1:0]    fill_vec;
    logic [MAX_OUT-1:0]     free_vec;
    logic                   any_valid;

    logic                   pend_found;
    logic [LANE_W-1:0]      pend_idx;
    logic                   free_found;
    logic [SLOT_W-1:0]      free_idx;

    logic [5:0]             tid_off;
    logic [SLOT_W-1:0]      resp_slot;
    logic                   resp_hit;
    logic [LINE_W-1:0]      resp_line;
    logic                   req_fire;
    logic                   accept;

    assign clr       = !rst_n || spmv_init;
    assign accept    = in_rdy && in_val;
    assign req_fire  = mem_req_val && mem_req_rdy;

    // A response belongs to us only if its transid maps onto a live slot.
    assign tid_off   = mem_resp_transid - TID_BASE;
    assign resp_slot = tid_off[SLOT_W-1:0];
    assign resp_hit  = mem_resp_val && (mem_resp_transid >= TID_BASE) &&
                       (tid_off < 6'(MAX_OUT)) && slots[resp_slot].valid;
    assign resp_line = slots[resp_slot].line;

    assign mem_req_addr    = {lane_line[pend_idx], 6'b0};
    assign mem_req_transid = TID_BASE + 6'(free_idx);

    // Per-lane line/word decode, outstanding-line match, and fill selection.
    always_comb begin
        pending  = '0;
        fill_vec = '0;
        for (int i = 0; i < CHAN_NUM; i++) begin
            lane_line[i] = line_of(base_q, 32'(col_q[i]));
            lane_word[i] = word_of(base_q, 32'(col_q[i]));
            pending[i]   = !filled[i];
            for (int s = 0; s < MAX_OUT; s++) begin
                if (slots[s].valid && (slots[s].line == lane_line[i])) begin
                    pending[i] = 1'b0;
                end
            end
            fill_vec[i] = resp_hit && !filled[i] && (lane_line[i] == resp_line);
        end
    end

    // Slot occupancy summary for allocation and the end-of-gather condition.
    always_comb begin
        free_vec  = '0;
        any_valid = 1'b0;
        for (int s = 0; s < MAX_OUT; s++) begin
            free_vec[s] = !slots[s].valid;
            any_valid   = any_valid | slots[s].valid;
        end
    end

    spmv_prio_enc #(.N(CHAN_NUM)) u_lane_enc (
        .req   (pending),
        .found (pend_found),
        .idx   (pend_idx)
    );

    spmv_prio_enc #(.N(MAX_OUT)) u_slot_enc (
        .req   (free_vec),
        .found (free_found),
        .idx   (free_idx)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (clr) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next state and handshake outputs; OUT is entered only once no request is outstanding.
    always_comb begin
        state_nxt   = state;
        in_rdy      = 1'b0;
        mem_req_val = 1'b0;
        out_val     = 1'b0;
        case (state)
            ST_IDLE: begin
                in_rdy = 1'b1;
                if (in_val) state_nxt = ST_GATHER;
            end
            ST_GATHER: begin
                mem_req_val = pend_found && free_found;
                if ((&filled) && !any_valid) state_nxt = ST_OUT;
            end
            ST_OUT: begin
                out_val = 1'b1;
                if (out_rdy) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Beat capture: column indices and vector base are held for the whole gather.
    always_ff @(posedge clk) begin
        if (accept) begin
            base_q <= x_base;
            for (int i = 0; i < CHAN_NUM; i++) begin
                col_q[i] <= in_col_idx[i*SPM_ELE_W +: SPM_ELE_W];
            end
        end
    end

    // Lane fill tracking and x data; masked lanes start filled and stay zero.
    always_ff @(posedge clk) begin
        if (clr) begin
            filled <= '0;
            for (int i = 0; i < CHAN_NUM; i++) x_q[i] <= '0;
        end else if (accept) begin
            filled <= ~in_lane_mask;
            for (int i = 0; i < CHAN_NUM; i++) x_q[i] <= '0;
        end else begin
            filled <= filled | fill_vec;
            for (int i = 0; i < CHAN_NUM; i++) begin
                if (fill_vec[i]) begin
                    x_q[i] <= SPM_ELE_W'(mem_resp_data[32*lane_word[i] +: 32]);
                end
            end
        end
    end

    // Slot table: a response frees its slot, a request handshake claims one (claim applied last).
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int s = 0; s < MAX_OUT; s++) slots[s] <= '0;
        end else begin
            if (resp_hit) slots[resp_slot].valid <= 1'b0;
            if (req_fire) slots[free_idx] <= '{valid: 1'b1, line: lane_line[pend_idx]};
        end
    end

    // Flatten lane values onto the output bus.
    always_comb begin
        out_x = '0;
        for (int i = 0; i < CHAN_NUM; i++) begin
            out_x[i*SPM_ELE_W +: SPM_ELE_W] = x_q[i];
        end
    end

endmodule

// File: tb/tb_spmv_x_gather.sv
// Directed bench for spmv_x_gather: a small memory model answers line
// requests with word value = (byte_addr/4) - 1024 + 100, so x[c] for
// x_base=0x1000 reads 100+c and for x_base=0x2000 reads 1124+c.
module tb_spmv_x_gather;

    logic         clk;
    logic         rst_n;
    logic         spmv_init;
    logic [39:0]  x_base;
    logic         in_val;
    logic         in_rdy;
    logic [511:0] in_col_idx;
    logic [15:0]  in_lane_mask;
    logic         mem_req_rdy;
    logic         mem_req_val;
    logic [5:0]   mem_req_transid;
    logic [39:0]  mem_req_addr;
    logic         mem_resp_val;
    logic [5:0]   mem_resp_transid;
    logic [511:0] mem_resp_data;
    logic         out_val;
    logic         out_rdy;
    logic [511:0] out_x;

    int checks;
    int failures;

    int          req_count;
    logic [5:0]  log_tid  [64];
    logic [39:0] log_addr [64];

    logic [31:0]  cols [16];
    logic [511:0] exp_x;

    spmv_x_gather dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .spmv_init        (spmv_init),
        .x_base           (x_base),
        .in_val           (in_val),
        .in_rdy           (in_rdy),
        .in_col_idx       (in_col_idx),
        .in_lane_mask     (in_lane_mask),
        .mem_req_rdy      (mem_req_rdy),
        .mem_req_val      (mem_req_val),
        .mem_req_transid  (mem_req_transid),
        .mem_req_addr     (mem_req_addr),
        .mem_resp_val     (mem_resp_val),
        .mem_resp_transid (mem_resp_transid),
        .mem_resp_data    (mem_resp_data),
        .out_val          (out_val),
        .out_rdy          (out_rdy),
        .out_x            (out_x)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Request monitor: log every handshaken request.
    initial req_count = 0;
    always @(posedge clk) begin
        if (rst_n && !spmv_init && mem_req_val && mem_req_rdy) begin
            log_tid[req_count[5:0]]  = mem_req_transid;
            log_addr[req_count[5:0]] = mem_req_addr;
            req_count = req_count + 1;
        end
    end

    function automatic logic [511:0] make_line(input logic [39:0] addr);
        logic [511:0] l;
        logic [39:0]  wa;
        for (int w = 0; w < 16; w++) begin
            wa = (addr >> 2) + 40'(w);
            l[32*w +: 32] = wa[31:0] - 32'd1024 + 32'd100;
        end
        return l;
    endfunction

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [39:0] base, input logic [15:0] mask);
        int budget;
        budget = 200;
        while (!in_rdy && budget > 0) begin
            tick();
            budget--;
        end
        chk("in_rdy_before_beat", in_rdy, 1);
        x_base       = base;
        in_lane_mask = mask;
        for (int i = 0; i < 16; i++) in_col_idx[32*i +: 32] = cols[i];
        in_val = 1'b1;
        tick();
        in_val = 1'b0;
    endtask

    task automatic respond(input logic [5:0] tid, input logic [511:0] data);
        mem_resp_val     = 1'b1;
        mem_resp_transid = tid;
        mem_resp_data    = data;
        tick();
        mem_resp_val     = 1'b0;
        mem_resp_data    = '0;
    endtask

    task automatic wait_reqs(input string tag, input int base, input int n);
        int budget;
        budget = 100;
        while ((req_count - base) < n && budget > 0) begin
            tick();
            budget--;
        end
        tick();
        tick();
        chk(tag, 512'(req_count - base), 512'(n));
    endtask

    task automatic wait_out(input string tag);
        int budget;
        budget = 200;
        while (!out_val && budget > 0) begin
            tick();
            budget--;
        end
        chk(tag, out_val, 1);
    endtask

    task automatic handshake_out(input string tag);
        out_rdy = 1'b1;
        tick();
        out_rdy = 1'b0;
        chk({tag, "_out_val_low"}, out_val, 0);
        chk({tag, "_in_rdy_high"}, in_rdy, 1);
    endtask

    initial begin
        int base;
        int rd;
        int done;
        int budget;
        int order [4];
        logic [511:0] held;

        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        spmv_init = 1'b0;
        x_base = '0;
        in_val = 1'b0;
        in_col_idx = '0;
        in_lane_mask = '0;
        mem_req_rdy = 1'b1;
        mem_resp_val = 1'b0;
        mem_resp_transid = '0;
        mem_resp_data = '0;
        out_rdy = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("rst_in_rdy", in_rdy, 1);
        chk("rst_mem_req_val", mem_req_val, 0);
        chk("rst_out_val", out_val, 0);
        chk("rst_out_x", out_x, 0);
        rst_n = 1'b1;
        tick();

        // Contiguous: one line serves all lanes
        base = req_count;
        for (int i = 0; i < 16; i++) cols[i] = 32'(i);
        send_beat(40'h1000, 16'hFFFF);
        wait_reqs("contig_req_count", base, 1);
        chk("contig_addr", log_addr[base[5:0]], 40'h1000);
        chk("contig_tid", log_tid[base[5:0]], 6'd8);
        respond(log_tid[base[5:0]], make_line(log_addr[base[5:0]]));
        wait_out("contig_out_val");
        for (int i = 0; i < 16; i++) exp_x[32*i +: 32] = 32'(100 + i);
        chk("contig_out_x", out_x, exp_x);
        handshake_out("contig");

        // Scatter: 16 distinct lines through 4 slots
        base = req_count;
        for (int i = 0; i < 16; i++) cols[i] = 32'(i * 16);
        send_beat(40'h1000, 16'hFFFF);
        wait_reqs("scatter_first_burst", base, 4);
        for (int k = 0; k < 4; k++) begin
            chk("scatter_tid", log_tid[6'(base + k)], 6'(8 + k));
            chk("scatter_addr", log_addr[6'(base + k)], 40'h1000 + 40'(64 * k));
        end
        chk("scatter_stall", mem_req_val, 0);
        rd = base;
        done = 0;
        budget = 400;
        while (done < 16 && budget > 0) begin
            if (rd < req_count) begin
                respond(log_tid[rd[5:0]], make_line(log_addr[rd[5:0]]));
                rd++;
                done++;
            end else begin
                tick();
            end
            budget--;
        end
        wait_out("scatter_out_val");
        chk("scatter_req_total", 512'(req_count - base), 512'(16));
        for (int i = 0; i < 16; i++) exp_x[32*i +: 32] = 32'(100 + 16 * i);
        chk("scatter_out_x", out_x, exp_x);
        handshake_out("scatter");

        // Masking: only lane 0 active
        base = req_count;
        for (int i = 0; i < 16; i++) cols[i] = 32'd7777;
        cols[0] = 32'd5;
        send_beat(40'h1000, 16'h0001);
        wait_reqs("mask1_req_count", base, 1);
        chk("mask1_addr", log_addr[base[5:0]], 40'h1000);
        chk("mask1_tid", log_tid[base[5:0]], 6'd8);
        respond(log_tid[base[5:0]], make_line(log_addr[base[5:0]]));
        wait_out("mask1_out_val");
        exp_x = '0;
        exp_x[31:0] = 32'd105;
        chk("mask1_out_x", out_x, exp_x);
        handshake_out("mask1");

        // Fully masked beat: no request, out_val two cycles after accept
        base = req_count;
        send_beat(40'h1000, 16'h0000);
        chk("mask0_out_val_cycle1", out_val, 0);
        tick();
        chk("mask0_out_val_cycle2", out_val, 1);
        chk("mask0_no_req", 512'(req_count - base), 512'(0));
        chk("mask0_out_x", out_x, 0);
        handshake_out("mask0");

        // Out-of-order responses with a foreign transid injected
        base = req_count;
        for (int i = 0; i < 16; i++) cols[i] = 32'((i / 4) * 16 + (i % 4));
        send_beat(40'h1000, 16'hFFFF);
        wait_reqs("ooo_req_count", base, 4);
        order[0] = 3; order[1] = 1; order[2] = 0; order[3] = 2;
        for (int k = 0; k < 4; k++) begin
            respond(6'(8 + order[k]), make_line(log_addr[6'(base + order[k])]));
            if (k == 0) respond(6'd1, {512{1'b1}});
            chk("ooo_out_val_while_busy", out_val, 0);
        end
        tick();
        chk("ooo_out_val_after_last_free", out_val, 1);
        chk("ooo_no_extra_req", 512'(req_count - base), 512'(4));
        for (int i = 0; i < 16; i++) exp_x[32*i +: 32] = 32'(100 + (i / 4) * 16 + (i % 4));
        chk("ooo_out_x", out_x, exp_x);

        // Backpressure: output held while out_rdy stays low
        held = exp_x;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("bp_out_x_stable", out_x, held);
            chk("bp_out_val", out_val, 1);
            chk("bp_in_rdy", in_rdy, 0);
        end
        handshake_out("bp");

        // spmv_init mid-gather, late responses, then a clean beat
        base = req_count;
        for (int i = 0; i < 16; i++) cols[i] = 32'(i * 16);
        send_beat(40'h1000, 16'hFFFF);
        wait_reqs("init_req_count", base, 4);
        spmv_init = 1'b1;
        tick();
        spmv_init = 1'b0;
        chk("init_in_rdy", in_rdy, 1);
        chk("init_mem_req_val", mem_req_val, 0);
        chk("init_out_val", out_val, 0);
        for (int k = 0; k < 4; k++) begin
            respond(6'(8 + k), make_line(log_addr[6'(base + k)]));
            chk("late_resp_in_rdy", in_rdy, 1);
            chk("late_resp_out_val", out_val, 0);
        end
        base = req_count;
        for (int i = 0; i < 16; i++) cols[i] = 32'(i);
        send_beat(40'h2000, 16'hFFFF);
        wait_reqs("post_init_req_count", base, 1);
        chk("post_init_addr", log_addr[base[5:0]], 40'h2000);
        chk("post_init_tid", log_tid[base[5:0]], 6'd8);
        respond(log_tid[base[5:0]], make_line(log_addr[base[5:0]]));
        wait_out("post_init_out_val");
        for (int i = 0; i < 16; i++) exp_x[32*i +: 32] = 32'(1124 + i);
        chk("post_init_out_x", out_x, exp_x);
        handshake_out("post_init");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
